// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back byte cache with a block refill/write-back FSM
module data_cache #(
  parameter int INDEX_BITS = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [7:0]            writedata_i,
  output logic [7:0]            readdata_o,
  output logic                  busywait_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-3:0] mem_address_o,
  output logic [31:0]           mem_writedata_o,
  input  logic [31:0]           mem_readdata_i,
  input  logic                  mem_busywait_i
);
  localparam int TW = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int N = 1 << INDEX_BITS;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, a;
  logic [31:0] data_q [N];
  logic [TW-1:0] tag_q [N];
  logic [N-1:0] valid_q, dirty_q;
  logic [TW-1:0] tag;
  logic [INDEX_BITS-1:0] idx;
  logic [1:0] off;
  logic idle, hit, req, wr_hit;
  // the miss address is frozen outside IDLE so a dropped request still refills the right block
  assign idle = state_q == IDLE;
  assign a = idle ? address_i : addr_q;
  assign {tag, idx, off} = a;
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign req = read_i | write_i;
  assign wr_hit = idle && write_i && hit;
  assign readdata_o = (idle && read_i && !write_i && hit) ? data_q[idx][{off, 3'b000} +: 8] : 8'h00;
  always_comb begin
    state_d = state_q;
    busywait_o = 1'b1;
    mem_read_o = 1'b0;
    mem_write_o = 1'b0;
    mem_address_o = '0;
    mem_writedata_o = '0;
    unique case (state_q)
      IDLE: begin
        busywait_o = req && !hit;
        if (req && !hit) state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        mem_write_o = 1'b1;
        mem_address_o = {tag_q[idx], idx};
        mem_writedata_o = data_q[idx];
        if (!mem_busywait_i) state_d = FETCH;
      end
      FETCH: begin
        mem_read_o = 1'b1;
        mem_address_o = {tag, idx};
        if (!mem_busywait_i) state_d = UPDATE;
      end
      UPDATE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == UPDATE) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_hit) dirty_q[idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    addr_q <= a;
    if (state_q == UPDATE) begin
      data_q[idx] <= mem_readdata_i;
      tag_q[idx] <= tag;
    end else if (wr_hit) data_q[idx][{off, 3'b000} +: 8] <= writedata_i;
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed and random accesses checked against a flat byte-memory model
module tb_data_cache;
  logic clk = 1'b0, rst = 1'b0;
  logic read_i = 1'b0, write_i = 1'b0;
  logic [7:0] address_i = 8'h00, writedata_i = 8'h00, readdata_o;
  logic busywait_o, mem_read_o, mem_write_o, mem_busywait_i;
  logic [5:0] mem_address_o;
  logic [31:0] mem_writedata_o, mem_readdata_i;
  logic [31:0] mem [64];
  logic [5:0] rd_a = 6'd0;
  int mem_lat = 0, cnt = 0;
  int tests = 0, fails = 0;
  logic [7:0] ref_mem [256];
  bit m_valid [8];
  bit m_dirty [8];
  logic [2:0] m_tag [8];

  data_cache dut (
    .clk_i(clk), .rst_i(rst), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .writedata_i(writedata_i), .readdata_o(readdata_o),
    .busywait_o(busywait_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_address_o(mem_address_o), .mem_writedata_o(mem_writedata_o),
    .mem_readdata_i(mem_readdata_i), .mem_busywait_i(mem_busywait_i)
  );

  always #5 clk = ~clk;

  // memory stays busy for mem_lat cycles of each strobe, then completes
  assign mem_busywait_i = (mem_read_o | mem_write_o) && cnt < mem_lat;
  assign mem_readdata_i = mem[rd_a];
  always @(posedge clk) begin
    cnt <= ((mem_read_o | mem_write_o) && cnt < mem_lat) ? cnt + 1 : 0;
    if (mem_read_o) rd_a <= mem_address_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [7:0] ad, input logic [7:0] wd, input int lat);
    logic [2:0] idx, tg;
    logic [7:0] vb;
    bit hit, dirty;
    int stall, wb, fe, exp_stall;
    bit both;
    logic [5:0] wa, fa;
    logic [31:0] wdat, exp_wdat;
    idx = ad[4:2];
    tg = ad[7:5];
    hit = m_valid[idx] && m_tag[idx] == tg;
    dirty = !hit && m_valid[idx] && m_dirty[idx];
    exp_stall = hit ? 0 : 1 + (lat + 1) + 1 + (dirty ? lat + 1 : 0);
    vb = {m_tag[idx], idx, 2'b00};
    exp_wdat = {ref_mem[vb + 8'd3], ref_mem[vb + 8'd2], ref_mem[vb + 8'd1], ref_mem[vb]};
    @(negedge clk);
    read_i = rd; write_i = wr; address_i = ad; writedata_i = wd; mem_lat = lat;
    #1;
    stall = 0; wb = 0; fe = 0; both = 0; wa = '0; fa = '0; wdat = '0;
    while (busywait_o && stall < 500) begin
      if (mem_write_o) begin
        if (wb == 0) begin wa = mem_address_o; wdat = mem_writedata_o; end
        wb++;
        if (!mem_busywait_i) mem[mem_address_o] = mem_writedata_o;
      end
      if (mem_read_o) begin
        if (fe == 0) fa = mem_address_o;
        fe++;
      end
      if (mem_read_o && mem_write_o) both = 1;
      @(negedge clk); #1;
      stall++;
    end
    chk("stall_cycles", stall, exp_stall);
    chk("writeback_cycles", wb, dirty ? lat + 1 : 0);
    chk("fetch_cycles", fe, hit ? 0 : lat + 1);
    chk("strobe_overlap", {31'd0, both}, 32'd0);
    chk("strobes_idle", {30'd0, mem_read_o, mem_write_o}, 32'd0);
    if (dirty) begin
      chk("wb_address", {26'd0, wa}, {26'd0, vb[7:2]});
      chk("wb_data", wdat, exp_wdat);
    end
    if (!hit) chk("fetch_address", {26'd0, fa}, {26'd0, ad[7:2]});
    if (rd && !wr) chk("readdata", {24'd0, readdata_o}, {24'd0, ref_mem[ad]});
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
    m_dirty[idx] = hit ? (m_dirty[idx] | wr) : wr;
    m_valid[idx] = 1'b1;
    m_tag[idx] = tg;
    if (wr) ref_mem[ad] = wd;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[1] = 32'h44332211;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i >> 2][8 * (i % 4) +: 8];
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_busywait", {31'd0, busywait_o}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read_o, mem_write_o}, 32'd0);
    chk("rst_mem_address", {26'd0, mem_address_o}, 32'd0);
    chk("rst_mem_writedata", mem_writedata_o, 32'd0);
    chk("rst_readdata", {24'd0, readdata_o}, 32'd0);
    access(1, 0, 8'h05, 8'h00, 5);
    access(1, 0, 8'h04, 8'h00, 5);
    access(0, 1, 8'h06, 8'hAA, 5);
    access(1, 0, 8'h06, 8'h00, 5);
    chk("dirty_model", {31'd0, m_dirty[1]}, 32'd1);
    access(1, 0, 8'h26, 8'h00, 3);
    chk("wb_landed", mem[1], 32'h44AA2211);
    @(negedge clk);
    read_i = 1'b1; address_i = 8'h04; mem_lat = 10;
    repeat (3) @(negedge clk);
    #1 chk("fetch_before_reset", {31'd0, mem_read_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    @(negedge clk); #1;
    chk("post_reset_strobes", {30'd0, mem_read_o, mem_write_o}, 32'd0);
    chk("post_reset_miss", {31'd0, busywait_o}, 32'd1);
    @(posedge clk); #1 read_i = 1'b0;
    n = 0;
    while (busywait_o && n < 100) begin @(negedge clk); #1; n++; end
    chk("dropped_refill_done", {31'd0, busywait_o}, 32'd0);
    m_valid[1] = 1; m_dirty[1] = 0; m_tag[1] = 3'd0;
    access(1, 0, 8'h04, 8'h00, 2);
    access(1, 0, 8'h45, 8'h00, 0);
    access(1, 0, 8'h88, 8'h00, 20);
    access(0, 1, 8'h8B, 8'h5C, 20);
    access(1, 0, 8'hAB, 8'h00, 20);
    for (int k = 0; k < 80; k++) begin
      int r;
      r = $urandom_range(0, 3);
      access(r < 2 || r == 3, r >= 2, 8'($urandom), 8'($urandom), $urandom_range(0, 4));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
